// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the MEM stage and the data-memory responder.
// The master side issues requests and consumes responses; the slave side answers.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_size,
        output req_unsigned,
        output req_wdata,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_size,
        input  req_unsigned,
        input  req_wdata,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, fixed access latency,
// byte-lane stores and aligned, extended loads into an internal word array.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic resetn,
    dmem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam bit LAT1 = (LATENCY == 1);

    localparam logic [3:0] CNT_INIT =
        (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;

    logic        l_we;
    logic [31:0] l_addr;
    logic [1:0]  l_size;
    logic        l_uns;
    logic [31:0] l_wdata;

    logic [31:0] mem [DEPTH];

    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        commit;
    logic        handshake;

    logic        c_we;
    logic [31:0] c_addr;
    logic [1:0]  c_size;
    logic        c_uns;
    logic [31:0] c_wdata;

    logic          err;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [7:0]    ld_b;
    logic [15:0]   ld_h;
    logic [31:0]   ld_data;

    assign accept    = (state == IDLE) && bus.req_valid;
    assign commit    = (accept && LAT1)
                     || ((state == BUSY) && (cnt == 4'd0));
    assign handshake = (state == RESP) && bus.resp_ready;

    // With single-cycle latency the commit edge is the acceptance edge,
    // so the live bus is used instead of the not-yet-latched copy.
    always_comb begin
        if (state == IDLE) begin
            c_we    = bus.req_we;
            c_addr  = bus.req_addr;
            c_size  = bus.req_size;
            c_uns   = bus.req_unsigned;
            c_wdata = bus.req_wdata;
        end else begin
            c_we    = l_we;
            c_addr  = l_addr;
            c_size  = l_size;
            c_uns   = l_uns;
            c_wdata = l_wdata;
        end
    end

    // Illegal size, misalignment and out-of-range checks.
    always_comb begin
        err = 1'b0;
        if (c_size == 2'b11)
            err = 1'b1;
        if ((c_size == 2'b01) && c_addr[0])
            err = 1'b1;
        if ((c_size == 2'b10) && (c_addr[1:0] != 2'b00))
            err = 1'b1;
        if (|c_addr[31:AW+2])
            err = 1'b1;
    end

    assign idx  = c_addr[AW+1:2];
    assign word = mem[idx];

    // Byte enables and lane-replicated store data.
    always_comb begin
        be    = 4'b0000;
        wlane = c_wdata;
        unique case (1'b1)
            (c_size == 2'b00): begin
                be    = 4'b0001 << c_addr[1:0];
                wlane = {4{c_wdata[7:0]}};
            end
            (c_size == 2'b01): begin
                be    = c_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{c_wdata[15:0]}};
            end
            (c_size == 2'b10): begin
                be    = 4'b1111;
                wlane = c_wdata;
            end
            default: begin
                be    = 4'b0000;
                wlane = c_wdata;
            end
        endcase
    end

    // Lane selection and sign/zero extension of load data.
    always_comb begin
        ld_b = word[8*c_addr[1:0] +: 8];
        ld_h = c_addr[1] ? word[31:16] : word[15:0];
        unique case (1'b1)
            (c_size == 2'b00):
                ld_data = c_uns ? {24'd0, ld_b}
                                : {{24{ld_b[7]}}, ld_b};
            (c_size == 2'b01):
                ld_data = c_uns ? {16'd0, ld_h}
                                : {{16{ld_h[15]}}, ld_h};
            default:
                ld_data = word;
        endcase
    end

    // Control FSM: IDLE -> (BUSY) -> RESP -> IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (LAT1) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0)
                        state <= RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                RESP: begin
                    if (bus.resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the request fields on acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            l_we    <= 1'b0;
            l_addr  <= 32'd0;
            l_size  <= 2'b00;
            l_uns   <= 1'b0;
            l_wdata <= 32'd0;
        end else if (accept) begin
            l_we    <= bus.req_we;
            l_addr  <= bus.req_addr;
            l_size  <= bus.req_size;
            l_uns   <= bus.req_unsigned;
            l_wdata <= bus.req_wdata;
        end
    end

    // Response registers: loaded at commit, cleared at handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= err;
            rdata_q <= (err || c_we) ? 32'd0 : ld_data;
        end else if (handshake) begin
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end
    end

    // Array write at the commit edge; reset holds the FSM out of commit.
    always_ff @(posedge clk) begin
        if (commit && c_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = resetn && (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table on a LATENCY=2 instance,
// stall/reset sequences, and a back-to-back stream on a LATENCY=1 instance.
module tb_dmem_responder;

    logic clk;
    logic resetn;

    dmem_responder_if bus0();
    dmem_responder_if bus1();

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    dmem_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    int pass_cnt = 0;
    int total    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
    endtask

    task automatic drive0(input vec_t v);
        bus0.req_we       = v.we;
        bus0.req_addr     = v.addr;
        bus0.req_size     = v.size;
        bus0.req_unsigned = v.uns;
        bus0.req_wdata    = v.wdata;
        bus0.req_valid    = 1'b1;
    endtask

    task automatic do_req(input vec_t v, input string nm);
        int n;
        int lat;
        @(negedge clk);
        drive0(v);
        n = 0;
        while (!bus0.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " ready"}, 32'(bus0.req_ready), 32'd1);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        lat = 1;
        while (!bus0.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'd2);
        chk({nm, " rdata"}, bus0.resp_rdata, v.rdata);
        chk({nm, " err"}, 32'(bus0.resp_err), 32'(v.err));
        bus0.resp_ready = 1'b1;
        @(negedge clk);
        bus0.resp_ready = 1'b0;
    endtask

    vec_t tv [19];
    vec_t sv [7];
    vec_t hv;

    initial begin
        tv[0]  = '{1, 32'h10,   2'b10, 0, 32'hDEADBEEF, 32'h0,        0};
        tv[1]  = '{0, 32'h10,   2'b10, 0, 32'h0,        32'hDEADBEEF, 0};
        tv[2]  = '{1, 32'h13,   2'b00, 0, 32'h00000080, 32'h0,        0};
        tv[3]  = '{0, 32'h13,   2'b00, 0, 32'h0,        32'hFFFFFF80, 0};
        tv[4]  = '{0, 32'h13,   2'b00, 1, 32'h0,        32'h00000080, 0};
        tv[5]  = '{0, 32'h10,   2'b10, 0, 32'h0,        32'h80ADBEEF, 0};
        tv[6]  = '{0, 32'h11,   2'b01, 0, 32'h0,        32'h0,        1};
        tv[7]  = '{1, 32'h12,   2'b10, 0, 32'h12345678, 32'h0,        1};
        tv[8]  = '{0, 32'h10,   2'b10, 0, 32'h0,        32'h80ADBEEF, 0};
        tv[9]  = '{0, 32'h10,   2'b11, 0, 32'h0,        32'h0,        1};
        tv[10] = '{1, 32'h0,    2'b10, 0, 32'h11111111, 32'h0,        0};
        tv[11] = '{1, 32'h1000, 2'b10, 0, 32'hCAFEF00D, 32'h0,        1};
        tv[12] = '{0, 32'h0,    2'b10, 0, 32'h0,        32'h11111111, 0};
        tv[13] = '{0, 32'h12,   2'b01, 1, 32'h0,        32'h000080AD, 0};
        tv[14] = '{0, 32'h10,   2'b01, 0, 32'h0,        32'hFFFFBEEF, 0};
        tv[15] = '{1, 32'h14,   2'b10, 0, 32'h0,        32'h0,        0};
        tv[16] = '{1, 32'h16,   2'b01, 0, 32'h5A5A1234, 32'h0,        0};
        tv[17] = '{0, 32'h14,   2'b10, 0, 32'h0,        32'h12340000, 0};
        tv[18] = '{0, 32'h17,   2'b00, 0, 32'h0,        32'h00000012, 0};

        sv[0] = '{1, 32'h0,  2'b10, 0, 32'h000000A1, 32'h0,        0};
        sv[1] = '{1, 32'h4,  2'b10, 0, 32'h000000B2, 32'h0,        0};
        sv[2] = '{0, 32'h0,  2'b10, 0, 32'h0,        32'h000000A1, 0};
        sv[3] = '{0, 32'h4,  2'b10, 0, 32'h0,        32'h000000B2, 0};
        sv[4] = '{1, 32'h1,  2'b00, 0, 32'h000000FF, 32'h0,        0};
        sv[5] = '{0, 32'h0,  2'b10, 0, 32'h0,        32'h0000FFA1, 0};
        sv[6] = '{0, 32'h40, 2'b10, 0, 32'h0,        32'h0,        1};

        resetn            = 1'b0;
        bus0.req_valid    = 1'b0;
        bus0.req_we       = 1'b0;
        bus0.req_addr     = 32'd0;
        bus0.req_size     = 2'b00;
        bus0.req_unsigned = 1'b0;
        bus0.req_wdata    = 32'd0;
        bus0.resp_ready   = 1'b0;
        bus1.req_valid    = 1'b0;
        bus1.req_we       = 1'b0;
        bus1.req_addr     = 32'd0;
        bus1.req_size     = 2'b00;
        bus1.req_unsigned = 1'b0;
        bus1.req_wdata    = 32'd0;
        bus1.resp_ready   = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst resp_valid", 32'(bus0.resp_valid), 32'd0);
        chk("rst rdata", bus0.resp_rdata, 32'd0);
        chk("rst err", 32'(bus0.resp_err), 32'd0);
        resetn = 1'b1;
        #1;
        chk("rst req_ready", 32'(bus0.req_ready), 32'd1);

        for (int i = 0; i < 19; i++)
            do_req(tv[i], $sformatf("vec%0d", i));

        // Stall in RESP with a competing request held on the bus.
        hv = '{0, 32'h10, 2'b10, 0, 32'h0, 32'h0, 0};
        @(negedge clk);
        drive0(hv);
        @(negedge clk);
        hv = '{1, 32'h10, 2'b10, 0, 32'h0, 32'h0, 0};
        drive0(hv);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d valid", c),
                32'(bus0.resp_valid), 32'd1);
            chk($sformatf("hold%0d rdata", c),
                bus0.resp_rdata, 32'h80ADBEEF);
            chk($sformatf("hold%0d err", c),
                32'(bus0.resp_err), 32'd0);
            chk($sformatf("hold%0d req_ready", c),
                32'(bus0.req_ready), 32'd0);
            @(negedge clk);
        end
        bus0.resp_ready = 1'b1;
        @(negedge clk);
        bus0.resp_ready = 1'b0;
        bus0.req_valid  = 1'b0;
        chk("post-hs valid", 32'(bus0.resp_valid), 32'd0);
        chk("post-hs rdata", bus0.resp_rdata, 32'd0);
        chk("post-hs req_ready", 32'(bus0.req_ready), 32'd1);
        hv = '{0, 32'h10, 2'b10, 0, 32'h0, 32'h80ADBEEF, 0};
        do_req(hv, "after hold");

        // Reset while a store is pending in BUSY.
        hv = '{1, 32'h10, 2'b10, 0, 32'h55555555, 32'h0, 0};
        @(negedge clk);
        drive0(hv);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        chk("busy req_ready", 32'(bus0.req_ready), 32'd0);
        chk("busy resp_valid", 32'(bus0.resp_valid), 32'd0);
        resetn = 1'b0;
        #1;
        chk("rst busy valid", 32'(bus0.resp_valid), 32'd0);
        chk("rst busy ready", 32'(bus0.req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rel req_ready", 32'(bus0.req_ready), 32'd1);
        hv = '{0, 32'h10, 2'b10, 0, 32'h0, 32'h80ADBEEF, 0};
        do_req(hv, "no commit");

        // Reset while a response is being presented.
        hv = '{0, 32'h0, 2'b10, 0, 32'h0, 32'h0, 0};
        @(negedge clk);
        drive0(hv);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        @(negedge clk);
        chk("resp pre-rst valid", 32'(bus0.resp_valid), 32'd1);
        chk("resp pre-rst rdata", bus0.resp_rdata, 32'h11111111);
        resetn = 1'b0;
        #1;
        chk("rst resp valid", 32'(bus0.resp_valid), 32'd0);
        chk("rst resp rdata", bus0.resp_rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Back-to-back stream on the single-cycle instance.
        begin
            int tx;
            int rx;
            int last;
            tx   = 0;
            rx   = 0;
            last = 0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                @(negedge clk);
                if (bus1.resp_valid) begin
                    if (rx < 7) begin
                        chk($sformatf("s%0d rdata", rx),
                            bus1.resp_rdata, sv[rx].rdata);
                        chk($sformatf("s%0d err", rx),
                            32'(bus1.resp_err), 32'(sv[rx].err));
                        if (rx > 0)
                            chk($sformatf("s%0d gap", rx),
                                32'(cyc - last), 32'd2);
                    end
                    rx++;
                    last = cyc;
                end
                if (bus1.req_ready && tx < 7) begin
                    bus1.req_we       = sv[tx].we;
                    bus1.req_addr     = sv[tx].addr;
                    bus1.req_size     = sv[tx].size;
                    bus1.req_unsigned = sv[tx].uns;
                    bus1.req_wdata    = sv[tx].wdata;
                    bus1.req_valid    = 1'b1;
                    tx++;
                end else begin
                    bus1.req_valid = 1'b0;
                end
            end
            chk("stream count", 32'(rx), 32'd7);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
